// File: rtl/div.sv
// Iterative RV32M divide/remainder unit (div, divu, rem, remu).
// Radix-2 restoring division, one quotient bit per cycle, with busy/ready
// handshaking towards the pipeline.
// Optional build macro DIV_SKIP_EN: skip the leading zeros of |dividend| so
// that small dividends finish early; results are identical either way.
module div #(
  parameter int XLEN = 32
) (
  input  logic            rst,
  input  logic            clk,
  input  logic            enable,
  input  logic [3:0]      div_op,
  input  logic [XLEN-1:0] rdata1,
  input  logic [XLEN-1:0] rdata2,
  output logic [XLEN-1:0] result,
  output logic            ready,
  output logic            busy
);

  localparam int CW = $clog2(XLEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Two's-complement negation, kept in one place for operand and result fixup.
  function automatic logic [XLEN-1:0] neg(input logic [XLEN-1:0] v);
    return (~v) + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

`ifdef DIV_SKIP_EN
  // Leading-zero count; only meaningful for a non-zero argument.
  function automatic logic [CW-1:0] clz(input logic [XLEN-1:0] v);
    logic [CW-1:0] n;
    logic          found;
    n     = '0;
    found = 1'b0;
    for (int i = XLEN - 1; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n = n + CW'(1);
      end
    end
    return n;
  endfunction
`endif

  // State and datapath registers
  logic [1:0]      state_q,  state_d;
  logic [CW-1:0]   cnt_q,    cnt_d;
  logic [XLEN-1:0] rem_q,    rem_d;    // partial remainder
  logic [XLEN-1:0] quo_q,    quo_d;    // dividend shifting out, quotient bits shifting in
  logic [XLEN-1:0] dvs_q,    dvs_d;    // |divisor|
  logic            qneg_q,   qneg_d;   // negate quotient at the end
  logic            rneg_q,   rneg_d;   // negate remainder at the end
  logic            oprem_q,  oprem_d;  // 1: rem/remu, 0: div/divu
  logic [XLEN-1:0] result_q, result_d;

  // Operation decode and operand preparation
  logic            sel_div, sel_divu, sel_rem, sel_remu;
  logic            op_signed, op_rem;
  logic            s1, s2;
  logic [XLEN-1:0] abs1, abs2;
  logic            dvs_zero, ovf, accept;

  // Iteration datapath
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic            ge;
  logic [XLEN-1:0] rem_it, quo_it;
  logic [XLEN-1:0] fin_q, fin_r, fin_res;

  assign ready  = (state_q == S_DONE);
  assign busy   = (state_q != S_IDLE);
  assign result = result_q;

  // Decode the one-hot op (div > divu > rem > remu) and form magnitudes.
  always_comb begin
    sel_div   = div_op[0];
    sel_divu  = ~div_op[0] & div_op[1];
    sel_rem   = ~div_op[0] & ~div_op[1] & div_op[2];
    sel_remu  = ~div_op[0] & ~div_op[1] & ~div_op[2] & div_op[3];
    op_signed = sel_div | sel_rem;
    op_rem    = sel_rem | sel_remu;
    s1        = op_signed & rdata1[XLEN-1];
    s2        = op_signed & rdata2[XLEN-1];
    abs1      = s1 ? neg(rdata1) : rdata1;
    abs2      = s2 ? neg(rdata2) : rdata2;
    dvs_zero  = (rdata2 == '0);
    ovf       = op_signed && (rdata1 == {1'b1, {(XLEN-1){1'b0}}}) && (rdata2 == '1);
    accept    = (state_q == S_IDLE) && enable && (div_op != 4'b0000);
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // The remainder is kept below the divisor, so XLEN+1 bits hold the shifted value.
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    diff    = shifted - {1'b0, dvs_q};
    ge      = (shifted >= {1'b0, dvs_q});
    rem_it  = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quo_it  = {quo_q[XLEN-2:0], ge};
    fin_q   = qneg_q ? neg(quo_it) : quo_it;
    fin_r   = rneg_q ? neg(rem_it) : rem_it;
    fin_res = oprem_q ? fin_r : fin_q;
  end

  // Next-state logic: acceptance, iteration and the special-case shortcuts.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    oprem_d  = oprem_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          oprem_d = op_rem;
          qneg_d  = s1 ^ s2;
          rneg_d  = s1;
          rem_d   = '0;
          dvs_d   = abs2;
          if (dvs_zero) begin
            result_d = op_rem ? rdata1 : '1;
            state_d  = S_DONE;
          end else if (ovf) begin
            result_d = op_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
            state_d  = S_DONE;
`ifdef DIV_SKIP_EN
          end else if (abs1 == '0) begin
            result_d = '0;
            state_d  = S_DONE;
          end else begin
            quo_d   = abs1 << clz(abs1);
            cnt_d   = CW'(XLEN - 1) - clz(abs1);
            state_d = S_CALC;
          end
`else
          end else begin
            quo_d   = abs1;
            cnt_d   = CW'(XLEN - 1);
            state_d = S_CALC;
          end
`endif
        end
      end
      S_CALC: begin
        rem_d = rem_it;
        quo_d = quo_it;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          result_d = fin_res;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Register update with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      oprem_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      oprem_q  <= oprem_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_div.sv
// Directed testbench for the iterative divide/remainder unit.
module tb_div;

  localparam logic [3:0] OP_DIV  = 4'b0001;
  localparam logic [3:0] OP_DIVU = 4'b0010;
  localparam logic [3:0] OP_REM  = 4'b0100;
  localparam logic [3:0] OP_REMU = 4'b1000;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [3:0]  div_op;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic [31:0] result;
  logic        ready;
  logic        busy;

  int tests_run = 0;
  int fail_cnt  = 0;

  div #(.XLEN(32)) dut (
    .rst    (rst),
    .clk    (clk),
    .enable (enable),
    .div_op (div_op),
    .rdata1 (rdata1),
    .rdata2 (rdata2),
    .result (result),
    .ready  (ready),
    .busy   (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Issue one request from IDLE; lat counts edges from E0 (inclusive) until
  // ready is seen, -1 if it never comes.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] res);
    @(posedge clk); #1;
    div_op = op; rdata1 = a; rdata2 = b; enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0; div_op = 4'b0000;
    lat = 1;
    while (!ready && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!ready) lat = -1;
    res = result;
  endtask

  task automatic test_reset;
    rst = 1'b0; enable = 1'b0; div_op = 4'b0000; rdata1 = '0; rdata2 = '0;
    #12;
    tests_run++;
    if (result !== 32'h0) begin fail_cnt++; $display("FAIL reset_result got %h want %h", result, 32'h0); end
    tests_run++;
    if (ready !== 1'b0) begin fail_cnt++; $display("FAIL reset_ready got %b want 0", ready); end
    tests_run++;
    if (busy !== 1'b0) begin fail_cnt++; $display("FAIL reset_busy got %b want 0", busy); end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_unsigned;
    int lat; logic [31:0] res; int exp_lat;
`ifdef DIV_SKIP_EN
    exp_lat = 8;  // 100 has 25 leading zeros: 7 iterations + 1
`else
    exp_lat = 33;
`endif
    do_op(OP_DIVU, 32'd100, 32'd7, lat, res);
    tests_run++;
    if (lat !== exp_lat) begin fail_cnt++; $display("FAIL divu_latency got %0d want %0d", lat, exp_lat); end
    tests_run++;
    if (res !== 32'd14) begin fail_cnt++; $display("FAIL divu_100_7 got %h want %h", res, 32'd14); end
    @(posedge clk); #1;
    tests_run++;
    if (ready !== 1'b0 || busy !== 1'b0) begin
      fail_cnt++; $display("FAIL ready_pulse got ready=%b busy=%b want 0 0", ready, busy);
    end
    tests_run++;
    if (result !== 32'd14) begin fail_cnt++; $display("FAIL result_hold got %h want %h", result, 32'd14); end
    do_op(OP_REMU, 32'd100, 32'd7, lat, res);
    tests_run++;
    if (res !== 32'd2) begin fail_cnt++; $display("FAIL remu_100_7 got %h want %h", res, 32'd2); end
  endtask

  task automatic test_signed;
    int lat; logic [31:0] res;
    do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, res);
    tests_run++;
    if (res !== 32'hFFFF_FFFD) begin fail_cnt++; $display("FAIL div_m7_2 got %h want %h", res, 32'hFFFF_FFFD); end
    do_op(OP_REM, 32'hFFFF_FFF9, 32'd2, lat, res);
    tests_run++;
    if (res !== 32'hFFFF_FFFF) begin fail_cnt++; $display("FAIL rem_m7_2 got %h want %h", res, 32'hFFFF_FFFF); end
    do_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, lat, res);
    tests_run++;
    if (res !== 32'hFFFF_FFFD) begin fail_cnt++; $display("FAIL div_7_m2 got %h want %h", res, 32'hFFFF_FFFD); end
    do_op(OP_REM, 32'd7, 32'hFFFF_FFFE, lat, res);
    tests_run++;
    if (res !== 32'd1) begin fail_cnt++; $display("FAIL rem_7_m2 got %h want %h", res, 32'd1); end
  endtask

  task automatic test_div_zero;
    int lat; logic [31:0] res;
    do_op(OP_DIV, 32'd5, 32'd0, lat, res);
    tests_run++;
    if (lat !== 1) begin fail_cnt++; $display("FAIL div0_latency got %0d want 1", lat); end
    tests_run++;
    if (res !== 32'hFFFF_FFFF) begin fail_cnt++; $display("FAIL div_5_0 got %h want %h", res, 32'hFFFF_FFFF); end
    @(posedge clk); #1;
    tests_run++;
    if (busy !== 1'b0) begin fail_cnt++; $display("FAIL div0_busy_one_cycle got %b want 0", busy); end
    do_op(OP_REMU, 32'd5, 32'd0, lat, res);
    tests_run++;
    if (res !== 32'd5) begin fail_cnt++; $display("FAIL remu_5_0 got %h want %h", res, 32'd5); end
    do_op(OP_REM, 32'hFFFF_FFF9, 32'd0, lat, res);
    tests_run++;
    if (res !== 32'hFFFF_FFF9) begin fail_cnt++; $display("FAIL rem_m7_0 got %h want %h", res, 32'hFFFF_FFF9); end
  endtask

  task automatic test_overflow;
    int lat; logic [31:0] res;
    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, res);
    tests_run++;
    if (lat !== 1) begin fail_cnt++; $display("FAIL ovf_latency got %0d want 1", lat); end
    tests_run++;
    if (res !== 32'h8000_0000) begin fail_cnt++; $display("FAIL div_ovf got %h want %h", res, 32'h8000_0000); end
    do_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, lat, res);
    tests_run++;
    if (res !== 32'h0) begin fail_cnt++; $display("FAIL rem_ovf got %h want %h", res, 32'h0); end
  endtask

  task automatic test_priority;
    int lat; logic [31:0] res;
    // remu|divu both set: divu wins, unsigned interpretation.
    do_op(4'b1010, 32'hFFFF_FFF9, 32'd2, lat, res);
    tests_run++;
    if (res !== 32'h7FFF_FFFC) begin fail_cnt++; $display("FAIL prio_divu got %h want %h", res, 32'h7FFF_FFFC); end
    // div_op == 0 must not start anything.
    @(posedge clk); #1;
    enable = 1'b1; div_op = 4'b0000; rdata1 = 32'd9; rdata2 = 32'd3;
    @(posedge clk); #1;
    enable = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || ready !== 1'b0) begin
      fail_cnt++; $display("FAIL op_zero_ignored got busy=%b ready=%b want 0 0", busy, ready);
    end
  endtask

  task automatic test_busy_ignore;
    int pulses; logic [31:0] prev;
    prev = result;
    @(posedge clk); #1;
    div_op = OP_DIVU; rdata1 = 32'h8000_0000; rdata2 = 32'd3; enable = 1'b1;
    @(posedge clk); #1;  // E0
    enable = 1'b0; div_op = 4'b0000;
    pulses = 0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (result !== prev) begin fail_cnt++; $display("FAIL result_stable_calc got %h want %h", result, prev); end
    repeat (2) @(posedge clk);
    #1;  // E0+5
    enable = 1'b1; div_op = OP_DIVU; rdata1 = 32'd1; rdata2 = 32'd1;
    @(posedge clk); #1;
    enable = 1'b0; div_op = 4'b0000;
    for (int i = 0; i < 60; i++) begin
      if (ready) pulses++;
      @(posedge clk); #1;
    end
    tests_run++;
    if (pulses !== 1) begin fail_cnt++; $display("FAIL busy_single_ready got %0d want 1", pulses); end
    tests_run++;
    if (result !== 32'h2AAA_AAAA) begin fail_cnt++; $display("FAIL busy_result got %h want %h", result, 32'h2AAA_AAAA); end
  endtask

  task automatic test_reset_mid;
    int lat; logic [31:0] res;
    @(posedge clk); #1;
    div_op = OP_DIVU; rdata1 = 32'h8000_0000; rdata2 = 32'd1; enable = 1'b1;
    @(posedge clk); #1;  // E0
    enable = 1'b0; div_op = 4'b0000;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    tests_run++;
    if (busy !== 1'b0 || ready !== 1'b0 || result !== 32'h0) begin
      fail_cnt++; $display("FAIL mid_reset got busy=%b ready=%b result=%h want 0 0 0", busy, ready, result);
    end
    #2 rst = 1'b1;
    do_op(OP_DIVU, 32'd9, 32'd3, lat, res);
    tests_run++;
    if (res !== 32'd3) begin fail_cnt++; $display("FAIL after_reset_divu got %h want %h", res, 32'd3); end
  endtask

  task automatic test_skip;
    int lat; logic [31:0] res; int exp3; int exp0;
`ifdef DIV_SKIP_EN
    exp3 = 3; exp0 = 1;
`else
    exp3 = 33; exp0 = 33;
`endif
    do_op(OP_DIVU, 32'd3, 32'd1, lat, res);
    tests_run++;
    if (lat !== exp3) begin fail_cnt++; $display("FAIL skip_latency_3_1 got %0d want %0d", lat, exp3); end
    tests_run++;
    if (res !== 32'd3) begin fail_cnt++; $display("FAIL divu_3_1 got %h want %h", res, 32'd3); end
    do_op(OP_DIVU, 32'd0, 32'd5, lat, res);
    tests_run++;
    if (lat !== exp0) begin fail_cnt++; $display("FAIL skip_latency_0_5 got %0d want %0d", lat, exp0); end
    tests_run++;
    if (res !== 32'd0) begin fail_cnt++; $display("FAIL divu_0_5 got %h want %h", res, 32'd0); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_priority();
    test_busy_ignore();
    test_reset_mid();
    test_skip();
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
